// File: rtl/pico_pkg.sv
// Shared types and constants for the picoMIPS switch input stage.
// Provides the per-bit debouncer state encoding and the default data width /
// branch-flag bit position used by sw_input_conditioner.
package pico_pkg;

  typedef enum logic {DB_STABLE, DB_PENDING} db_state_t;

  localparam int unsigned DATA_W   = 8;       // ALU operand width
  localparam int unsigned FLAG_BIT = DATA_W;  // branch flag sits just above the data bits

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch conditioner: two-flop synchroniser followed by a
// STABLE/PENDING debouncer that only accepts a level held for DB_CYCLES edges.
// Ports:
//   clk, reset   - system clock, async active-high reset
//   sw_raw       - asynchronous raw switch bit
//   clean        - registered debounced level
//   clean_nxt_c  - value clean takes at the next edge (lets the parent detect
//                  edges in the same cycle clean updates)
module sw_debounce #(
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic clean,
  output logic clean_nxt_c
);

  import pico_pkg::*;

  localparam int unsigned CW     = $clog2(DB_CYCLES + 1);
  localparam bit          SINGLE = (DB_CYCLES == 1);

  logic          s1;
  logic          s2;
  db_state_t     state;
  db_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          diff_c;
  logic          last_c;

  assign diff_c = (s2 != clean);
  assign last_c = (cnt == CW'(DB_CYCLES - 1));

  // Two-flop synchroniser, nothing between the flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // State, counter and clean level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DB_STABLE;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      clean <= clean_nxt_c;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      DB_STABLE:  if (diff_c && !SINGLE) state_nxt = DB_PENDING;
      DB_PENDING: if (!diff_c || last_c) state_nxt = DB_STABLE;
      default:    state_nxt = DB_STABLE;
    endcase
  end

  // Counter and clean-level updates.
  always_comb begin
    cnt_nxt     = '0;
    clean_nxt_c = clean;
    case (state)
      DB_STABLE: begin
        if (diff_c) begin
          if (SINGLE) clean_nxt_c = s2;
          else        cnt_nxt     = CW'(1);
        end
      end
      DB_PENDING: begin
        if (diff_c) begin
          if (last_c) clean_nxt_c = s2;
          else        cnt_nxt     = cnt + CW'(1);
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

endmodule

// File: rtl/sw_input_conditioner.sv
// Switch input stage for the picoMIPS core: debounces SW[N:0], captures the
// data byte on each debounced flag rise and tracks a pending/ack handshake.
// Ports:
//   clk, reset             - system clock, async active-high reset
//   sw_raw[N:0]            - raw switches, bit N is the branch flag
//   flag_ack               - core has consumed the pending event
//   sw_clean[N:0], bflag   - debounced levels / debounced flag
//   data_q[N-1:0]          - data byte latched at the last flag rise
//   flag_rise, flag_fall   - one-cycle debounced edge pulses
//   evt_pending, overrun   - handshake state, overrun is sticky until ack
module sw_input_conditioner
  import pico_pkg::*;
#(
  parameter int unsigned N         = DATA_W,
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N:0]   sw_raw,
  input  logic         flag_ack,
  output logic [N:0]   sw_clean,
  output logic         bflag,
  output logic [N-1:0] data_q,
  output logic         flag_rise,
  output logic         flag_fall,
  output logic         evt_pending,
  output logic         overrun
);

  logic [N:0] clean_nxt_c;
  logic       rise_c;
  logic       fall_c;
  logic       ack_c;
  logic       unused_data_nxt;

  // One synchroniser + debouncer per switch bit.
  for (genvar i = 0; i <= N; i++) begin : g_bit
    sw_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk         (clk),
      .reset       (reset),
      .sw_raw      (sw_raw[i]),
      .clean       (sw_clean[i]),
      .clean_nxt_c (clean_nxt_c[i])
    );
  end

  // Only the flag lookahead is needed; data bits are captured from sw_clean.
  assign unused_data_nxt = ^clean_nxt_c[N-1:0];

  assign bflag  = sw_clean[N];
  assign rise_c = clean_nxt_c[N] & ~sw_clean[N];
  assign fall_c = ~clean_nxt_c[N] & sw_clean[N];
  assign ack_c  = flag_ack & evt_pending;

  // Edge pulses, capture and handshake all update on the edge that moves the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_rise   <= 1'b0;
      flag_fall   <= 1'b0;
      data_q      <= '0;
      evt_pending <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      flag_rise <= rise_c;
      flag_fall <= fall_c;
      if (rise_c) data_q <= sw_clean[N-1:0];

      if (rise_c)     evt_pending <= 1'b1;
      else if (ack_c) evt_pending <= 1'b0;

      // A rise that coincides with an ack is a clean hand-over, not an overrun.
      if (rise_c && evt_pending && !flag_ack) overrun <= 1'b1;
      else if (ack_c)                         overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with N=8, DB_CYCLES=3.
module tb_sw_input_conditioner;

  localparam int unsigned N  = 8;
  localparam int unsigned DB = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N:0]   sw_raw;
  logic         flag_ack;
  logic [N:0]   sw_clean;
  logic         bflag;
  logic [N-1:0] data_q;
  logic         flag_rise;
  logic         flag_fall;
  logic         evt_pending;
  logic         overrun;

  int checks   = 0;
  int failures = 0;
  int rises;

  always #5 clk = ~clk;

  sw_input_conditioner #(.N(N), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_raw      (sw_raw),
    .flag_ack    (flag_ack),
    .sw_clean    (sw_clean),
    .bflag       (bflag),
    .data_q      (data_q),
    .flag_rise   (flag_rise),
    .flag_fall   (flag_fall),
    .evt_pending (evt_pending),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; sample/drive 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle(input logic [N:0] v);
    sw_raw = v;
    step(7);
  endtask

  task automatic ack_pulse();
    flag_ack = 1'b1;
    step(1);
    flag_ack = 1'b0;
  endtask

  task automatic count_rises(input int n);
    repeat (n) begin
      step(1);
      rises += int'(flag_rise);
    end
  endtask

  initial begin
    reset    = 1'b1;
    sw_raw   = 9'h1FF;
    flag_ack = 1'b0;

    // Reset state with switches all high
    step(3);
    check("rst_clean",   32'(sw_clean),    32'h0);
    check("rst_bflag",   32'(bflag),       32'h0);
    check("rst_data",    32'(data_q),      32'h0);
    check("rst_rise",    32'(flag_rise),   32'h0);
    check("rst_fall",    32'(flag_fall),   32'h0);
    check("rst_pend",    32'(evt_pending), 32'h0);
    check("rst_ovr",     32'(overrun),     32'h0);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("rst_lat_clean", 32'(sw_clean),  32'h0);
      check("rst_lat_rise",  32'(flag_rise), 32'h0);
    end
    step(1);
    check("rst_e5_clean", 32'(sw_clean),    32'h1FF);
    check("rst_e5_bflag", 32'(bflag),       32'h1);
    check("rst_e5_rise",  32'(flag_rise),   32'h1);
    check("rst_e5_pend",  32'(evt_pending), 32'h1);
    check("rst_e5_data",  32'(data_q),      32'h00);
    step(1);
    check("rst_rise_1cyc", 32'(flag_rise), 32'h0);
    ack_pulse();
    check("rst_ack_pend", 32'(evt_pending), 32'h0);

    // Capture of A5
    sw_raw = 9'h0A5;
    step(5);
    check("cap_fall_clean", 32'(sw_clean),  32'h0A5);
    check("cap_fall",       32'(flag_fall), 32'h1);
    step(1);
    check("cap_fall_1cyc",  32'(flag_fall), 32'h0);
    sw_raw = 9'h1A5;
    step(4);
    check("cap_e4_rise",  32'(flag_rise), 32'h0);
    check("cap_e4_clean", 32'(sw_clean),  32'h0A5);
    step(1);
    check("cap_rise",  32'(flag_rise),   32'h1);
    check("cap_data",  32'(data_q),      32'hA5);
    check("cap_pend",  32'(evt_pending), 32'h1);
    check("cap_clean", 32'(sw_clean),    32'h1A5);
    step(1);
    check("cap_rise_1cyc", 32'(flag_rise), 32'h0);
    ack_pulse();
    check("cap_ack_pend", 32'(evt_pending), 32'h0);

    // Glitch rejection: 2-cycle pulse rejected, 3-cycle accepted
    settle(9'h0A5);
    rises  = 0;
    sw_raw = 9'h1A5;
    count_rises(2);
    sw_raw = 9'h0A5;
    count_rises(8);
    check("glitch2_rises", 32'(rises),       32'h0);
    check("glitch2_clean", 32'(sw_clean),    32'h0A5);
    check("glitch2_pend",  32'(evt_pending), 32'h0);
    rises  = 0;
    sw_raw = 9'h1A5;
    count_rises(3);
    sw_raw = 9'h0A5;
    count_rises(8);
    check("pulse3_rises", 32'(rises),       32'h1);
    check("pulse3_pend",  32'(evt_pending), 32'h1);
    check("pulse3_clean", 32'(sw_clean),    32'h0A5);
    ack_pulse();

    // Overrun: two rises without ack
    settle(9'h011);
    settle(9'h111);
    check("ovr_data1", 32'(data_q),  32'h11);
    check("ovr_none",  32'(overrun), 32'h0);
    settle(9'h022);
    settle(9'h122);
    check("ovr_data2", 32'(data_q),      32'h22);
    check("ovr_set",   32'(overrun),     32'h1);
    check("ovr_pend",  32'(evt_pending), 32'h1);
    ack_pulse();
    check("ovr_ack_pend", 32'(evt_pending), 32'h0);
    check("ovr_ack_ovr",  32'(overrun),     32'h0);

    // Rise and ack on the same edge
    settle(9'h033);
    settle(9'h133);
    check("sim_data1", 32'(data_q), 32'h33);
    settle(9'h044);
    sw_raw = 9'h144;
    step(4);
    flag_ack = 1'b1;
    step(1);
    flag_ack = 1'b0;
    check("sim_rise", 32'(flag_rise),   32'h1);
    check("sim_pend", 32'(evt_pending), 32'h1);
    check("sim_ovr",  32'(overrun),     32'h0);
    check("sim_data", 32'(data_q),      32'h44);
    step(1);
    check("sim_pend_hold", 32'(evt_pending), 32'h1);
    ack_pulse();

    // Reset mid-count, asynchronous clear and full latency restart
    settle(9'h044);
    sw_raw = 9'h144;
    step(3);
    reset = 1'b1;
    #1;
    check("mid_async_clean", 32'(sw_clean),    32'h0);
    check("mid_async_data",  32'(data_q),      32'h0);
    check("mid_async_pend",  32'(evt_pending), 32'h0);
    step(2);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("mid_lat_clean", 32'(sw_clean), 32'h0);
    end
    step(1);
    check("mid_e5_clean", 32'(sw_clean),    32'h144);
    check("mid_e5_rise",  32'(flag_rise),   32'h1);
    check("mid_e5_pend",  32'(evt_pending), 32'h1);
    check("mid_e5_data",  32'(data_q),      32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
